// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction-fetch front end: PC generator, credit-limited request port to a
// latency-tolerant instruction memory, and a DEPTH-entry in-order prefetch
// queue feeding decode over a valid/ready handshake. An execute-stage redirect
// flushes the queue and discards every response still in flight.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   imem_req_valid  fetch request valid (out)
//   imem_req_ready  memory accepts request (in)
//   imem_req_addr   fetch address (out)
//   imem_resp_valid returned instruction valid, in order, no back-pressure (in)
//   imem_resp_data  returned instruction (in)
//   redirect_valid  execute-stage redirect (in)
//   redirect_pc     redirect target (in)
//   dec_valid       queue head valid to decode (out)
//   dec_ready       decode accepts head (in)
//   instr_d         head instruction, nop when queue empty (out)
//   pc_d            head PC, 0 when queue empty (out)
//   pcplus4_d       pc_d + 4, 0 when queue empty (out)
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pcplus4_d
);

    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [XLEN-1:0] r_fetchPc;
    logic [XLEN-1:0] r_respPc;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_occ;
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_drop;
    logic [31:0]     r_instrMem [DEPTH];
    logic [XLEN-1:0] r_pcMem    [DEPTH];

    logic [CW:0]     w_inUse;
    logic            w_hasCredit;
    logic            w_reqFire;
    logic            w_push;
    logic            w_pop;
    logic            w_headValid;
    logic [CW-1:0]   w_outstAfterResp;

    // Every queued entry plus every in-flight request holds a credit, so a
    // response can always be pushed without checking for a full queue.
    assign w_inUse     = {1'b0, r_occ} + {1'b0, r_outst};
    assign w_hasCredit = w_inUse < (CW+1)'(DEPTH);

    assign imem_req_valid = reset & ~redirect_valid & w_hasCredit;
    assign imem_req_addr  = r_fetchPc;
    assign w_reqFire      = imem_req_valid & imem_req_ready;

    // Responses are dropped while older requests from before a redirect are
    // still draining, and also in the redirect cycle itself.
    assign w_push = imem_resp_valid & (r_drop == '0) & ~redirect_valid;

    assign w_headValid = (r_occ != '0);
    assign dec_valid   = w_headValid & ~redirect_valid;
    assign w_pop       = dec_valid & dec_ready;

    assign w_outstAfterResp = r_outst - CW'(imem_resp_valid);

    // The head outputs are gated by registered occupancy only, so they do not
    // depend combinationally on redirect_valid; dec_valid masks them instead.
    assign instr_d   = w_headValid ? r_instrMem[r_head] : NOP;
    assign pc_d      = w_headValid ? r_pcMem[r_head] : '0;
    assign pcplus4_d = w_headValid ? (r_pcMem[r_head] + XLEN'(4)) : '0;

    // Control state: PCs, pointers and counters. A redirect overrides every
    // other update in its cycle; the response arriving with it is counted out
    // of both outst and drop because it is discarded right here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetchPc <= RESET_PC;
            r_respPc  <= RESET_PC;
            r_head    <= '0;
            r_tail    <= '0;
            r_occ     <= '0;
            r_outst   <= '0;
            r_drop    <= '0;
        end else if (redirect_valid) begin
            r_fetchPc <= redirect_pc;
            r_respPc  <= redirect_pc;
            r_head    <= '0;
            r_tail    <= '0;
            r_occ     <= '0;
            r_outst   <= w_outstAfterResp;
            r_drop    <= w_outstAfterResp;
        end else begin
            if (w_reqFire) begin
                r_fetchPc <= r_fetchPc + XLEN'(4);
            end
            r_outst <= w_outstAfterResp + CW'(w_reqFire);
            if (imem_resp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_push) begin
                r_tail   <= r_tail + PW'(1);
                r_respPc <= r_respPc + XLEN'(4);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + CW'(1);
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - CW'(1);
            end
        end
    end

    // Queue storage needs no reset: an entry is only read after it was pushed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instrMem[r_tail] <= imem_resp_data;
            r_pcMem[r_tail]    <= r_respPc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Self-checking bench for fetch_queue: a table of per-cycle vectors for the
// reset-release stream and a redirect coincident with a response and a pop,
// hand-written sequences for back-pressure, in-flight redirect, mid-operation
// reset and push/pop at DEPTH-1, a wrap check on a second instance built with
// RESET_PC = FFFF_FFF8, and a long random run against a reference PC sequence.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;

    logic        wrapReqValid;
    logic        wrapReqReady;
    logic [31:0] wrapReqAddr;
    logic        wrapRespValid;
    logic [31:0] wrapRespData;
    logic        wrapRedirValid;
    logic [31:0] wrapRedirPc;
    logic        wrapDecValid;
    logic        wrapDecReady;
    logic [31:0] wrapInstr;
    logic [31:0] wrapPc;
    logic [31:0] wrapPc4;

    // Clock generation
    always #5 clk = ~clk;

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d)
    );

    fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(wrapReqValid), .imem_req_ready(wrapReqReady),
        .imem_req_addr(wrapReqAddr),
        .imem_resp_valid(wrapRespValid), .imem_resp_data(wrapRespData),
        .redirect_valid(wrapRedirValid), .redirect_pc(wrapRedirPc),
        .dec_valid(wrapDecValid), .dec_ready(wrapDecReady),
        .instr_d(wrapInstr), .pc_d(wrapPc), .pcplus4_d(wrapPc4)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        dr;
        logic        rv;
        logic [31:0] rpc;
        logic        expReqValid;
        logic [31:0] expReqAddr;
        logic        expDecValid;
        logic [31:0] expPc;
        logic        chkPc;
        logic        chkWrap;
        logic        expWrapValid;
        logic [31:0] expWrapAddr;
    } vec_t;

    pend_t       pq[$];
    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    int          lat      = 1;
    int          pops     = 0;
    logic        sbOn     = 1'b0;
    logic [31:0] expReqAddr = '0;
    logic [31:0] expDecPc   = '0;

    logic        sReqValid;
    logic [31:0] sReqAddr;
    logic        sDecValid;
    logic [31:0] sPc;
    logic [31:0] sInstr;
    logic [31:0] sPc4;
    logic        sWrapValid;
    logic [31:0] sWrapAddr;

    // One comparison: counts it and reports a mismatch
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge. Drives the inputs,
    // plays the memory (fixed latency per request, in order), samples the
    // outputs and, when enabled, checks them against the reference sequence.
    task automatic applyStimulus(input logic dr, input logic rv, input logic [31:0] rpc,
                                 input logic rdy);
        dec_ready      = dr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        if (pq.size() > 0 && pq[0].due <= cycle) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~pq[0].addr;
            pq.delete(0);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        sReqValid  = imem_req_valid;
        sReqAddr   = imem_req_addr;
        sDecValid  = dec_valid;
        sPc        = pc_d;
        sInstr     = instr_d;
        sPc4       = pcplus4_d;
        sWrapValid = wrapReqValid;
        sWrapAddr  = wrapReqAddr;
        if (imem_req_valid && rdy) begin
            pq.push_back('{imem_req_addr, cycle + lat});
        end
        if (sbOn) begin
            if (rv) begin
                checkOutput("sbRedirDecValid", {31'b0, dec_valid}, 32'd0);
                checkOutput("sbRedirReqValid", {31'b0, imem_req_valid}, 32'd0);
            end
            if (imem_req_valid && rdy) begin
                checkOutput("sbReqAddr", imem_req_addr, expReqAddr);
                expReqAddr += 32'd4;
            end
            if (dec_valid && dr) begin
                checkOutput("sbPc", pc_d, expDecPc);
                checkOutput("sbInstr", instr_d, ~expDecPc);
                checkOutput("sbPcPlus4", pcplus4_d, expDecPc + 32'd4);
                expDecPc += 32'd4;
                pops++;
            end
            checkOutput("sbCredit", {31'b0, (pq.size() <= DEPTH)}, 32'd1);
            if (rv) begin
                expReqAddr = rpc;
                expDecPc   = rpc;
            end
        end
        @(negedge clk);
        cycle++;
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge, then
    // released on a falling edge so the next cycle is the first with reset high
    task automatic doReset();
        #2;
        reset           = 1'b0;
        pq.delete();
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        dec_ready       = 1'b0;
        imem_req_ready  = 1'b0;
        #1;
        checkOutput("rstReqValid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("rstDecValid", {31'b0, dec_valid}, 32'd0);
        checkOutput("rstInstr", instr_d, 32'h0000_0013);
        checkOutput("rstPc", pc_d, 32'd0);
        checkOutput("rstPcPlus4", pcplus4_d, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset      = 1'b1;
        cycle      = 0;
        expReqAddr = 32'd0;
        expDecPc   = 32'd0;
    endtask

    // Main test sequence
    initial begin
        vec_t        vecs[11];
        int          reqCount;
        logic [31:0] firstAddr;
        logic        gotFirst;

        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        dec_ready       = 1'b0;
        wrapReqReady    = 1'b1;
        wrapRespValid   = 1'b0;
        wrapRespData    = '0;
        wrapRedirValid  = 1'b0;
        wrapRedirPc     = '0;
        wrapDecReady    = 1'b0;

        //             dr    rv    rpc            rqV   rqAddr         dV    pc             chk   wChk  wV    wAddr
        vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        1'b1, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        1'b1, 32'h4,        1'b1, 1'b1, 1'b1, 32'h0000_0004};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'h8,        1'b1, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h14,       1'b1, 32'hC,        1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 32'h200,      1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h200,      1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h204,      1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h208,      1'b1, 32'h200,      1'b1, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h20C,      1'b1, 32'h204,      1'b1, 1'b0, 1'b0, 32'h0};

        // Reset, then the table: stream at L=1 and a redirect landing on a
        // response and a pending pop
        doReset();
        lat = 1;
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].dr, vecs[i].rv, vecs[i].rpc, 1'b1);
            checkOutput($sformatf("vec%0d reqValid", i), {31'b0, sReqValid}, {31'b0, vecs[i].expReqValid});
            if (vecs[i].expReqValid) begin
                checkOutput($sformatf("vec%0d reqAddr", i), sReqAddr, vecs[i].expReqAddr);
            end
            checkOutput($sformatf("vec%0d decValid", i), {31'b0, sDecValid}, {31'b0, vecs[i].expDecValid});
            if (vecs[i].chkPc) begin
                checkOutput($sformatf("vec%0d pc", i), sPc, vecs[i].expPc);
                checkOutput($sformatf("vec%0d instr", i), sInstr,
                            vecs[i].expDecValid ? ~vecs[i].expPc : 32'h0000_0013);
                checkOutput($sformatf("vec%0d pcPlus4", i), sPc4,
                            vecs[i].expDecValid ? vecs[i].expPc + 32'd4 : 32'd0);
            end
            if (vecs[i].chkWrap) begin
                checkOutput($sformatf("vec%0d wrapValid", i), {31'b0, sWrapValid}, {31'b0, vecs[i].expWrapValid});
                if (vecs[i].expWrapValid) begin
                    checkOutput($sformatf("vec%0d wrapAddr", i), sWrapAddr, vecs[i].expWrapAddr);
                end
            end
        end

        // Back-pressure: four requests fill the credits, then drain in order
        doReset();
        lat      = 1;
        reqCount = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            if (sReqValid) reqCount++;
        end
        checkOutput("bpReqCount", reqCount, 32'd4);
        checkOutput("bpReqValidFull", {31'b0, sReqValid}, 32'd0);
        checkOutput("bpDecValidFull", {31'b0, sDecValid}, 32'd1);
        checkOutput("bpHeadPc", sPc, 32'h0);
        gotFirst  = 1'b0;
        firstAddr = '0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
            checkOutput($sformatf("bpDrainValid%0d", k), {31'b0, sDecValid}, 32'd1);
            checkOutput($sformatf("bpDrainPc%0d", k), sPc, 32'(4 * k));
            if (sReqValid && !gotFirst) begin
                gotFirst  = 1'b1;
                firstAddr = sReqAddr;
            end
        end
        checkOutput("bpResumeSeen", {31'b0, gotFirst}, 32'd1);
        checkOutput("bpResumeAddr", firstAddr, 32'h10);

        // Reset while the queue holds entries
        checkOutput("preResetDecValid", {31'b0, sDecValid}, 32'd1);
        doReset();

        // Redirect with three requests in flight (L=4)
        lat = 4;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("rdInFlight", pq.size(), 32'd3);
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b0);
        checkOutput("rdCycleDecValid", {31'b0, sDecValid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
            checkOutput($sformatf("rdDropDecValid%0d", i), {31'b0, sDecValid}, 32'd0);
            if (i == 0) begin
                checkOutput("rdNewReqValid", {31'b0, sReqValid}, 32'd1);
                checkOutput("rdNewReqAddr", sReqAddr, 32'h100);
            end
        end
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("rdFirstDecValid", {31'b0, sDecValid}, 32'd1);
        checkOutput("rdFirstPc", sPc, 32'h100);
        checkOutput("rdFirstInstr", sInstr, ~32'h100);

        // Push and pop together at occupancy DEPTH-1
        doReset();
        lat  = 1;
        sbOn = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("ppNoCredit", {31'b0, sReqValid}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("ppCreditBack", {31'b0, sReqValid}, 32'd1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

        // Address wrap through a redirect near the top of the address space
        pops = 0;
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("wrapPops", {31'b0, (pops >= 4)}, 32'd1);

        // Random ready, latency and redirects against the reference sequence
        pops = 0;
        for (int i = 0; i < 10000; i++) begin
            lat = $urandom_range(1, 4);
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                          $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
        end
        checkOutput("randomProgress", {31'b0, (pops >= 1000)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
